// File: rtl/id_pkg.sv
// Shared types for the RV32I decode stage: control bundle, ALU/mask encodings, FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package id_pkg;

    typedef enum logic [3:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef enum logic {
        ALU_SRC_RS2 = 1'b0,
        ALU_SRC_IMM = 1'b1
    } alu_src_e;

    typedef enum logic [1:0] {
        MASK_B = 2'd0,
        MASK_H = 2'd1,
        MASK_W = 2'd2
    } mask_e;

    typedef struct packed {
        alu_op_e    alu_op;
        alu_src_e   alu_src;
        logic       mem_read;
        logic       mem_write;
        mask_e      mask;
        logic       unsigned_load;
        logic       reg_write;
        logic       mem_to_reg;
        logic       is_branch;
        logic [2:0] br_funct;
    } id_ctrl_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } id_state_e;

    localparam id_ctrl_t ID_CTRL_NOP = '{
        alu_op:        ALU_NOP,
        alu_src:       ALU_SRC_RS2,
        mem_read:      1'b0,
        mem_write:     1'b0,
        mask:          MASK_W,
        unsigned_load: 1'b0,
        reg_write:     1'b0,
        mem_to_reg:    1'b0,
        is_branch:     1'b0,
        br_funct:      3'b000
    };

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Forwarding select codes for the ID branch operands
    localparam int FORWARD_NONE = 0;
    localparam int FORWARD_MEM  = 1;
    localparam int FORWARD_WB   = 2;

    // Branch condition from funct3 and the three raw compare results
    function automatic logic br_cond(input logic [2:0] f3, input logic eq,
                                     input logic lt, input logic ltu);
        logic r;
        case (f3)
            3'b000:  r = eq;
            3'b001:  r = !eq;
            3'b100:  r = lt;
            3'b101:  r = !lt;
            3'b110:  r = ltu;
            3'b111:  r = !ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decoder: register addresses/enables, immediates, control bundle, illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is consumed.
module id_decode
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     inst,
    output logic            rs1_rd_en,
    output logic            rs2_rd_en,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] br_off,
    output id_ctrl_t        ctrl,
    output logic            is_br,
    output logic            is_jal,
    output logic            is_jalr,
    output logic            illegal
);

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Opcode/funct decode; anything unrecognised collapses to a NOP marked illegal
    always_comb begin
        rs1_rd_en = 1'b0;
        rs2_rd_en = 1'b0;
        imm       = '0;
        br_off    = '0;
        ctrl      = ID_CTRL_NOP;
        is_br     = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        illegal   = 1'b0;

        case (opcode)
            OP_LUI, OP_AUIPC: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = ALU_SRC_IMM;
                ctrl.reg_write = 1'b1;
                imm = (opcode == OP_AUIPC) ? pc + sx(imm_u) : sx(imm_u);
            end
            OP_JAL: begin
                // Link value travels through the ALU as x0 + (pc+4)
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = ALU_SRC_IMM;
                ctrl.reg_write = 1'b1;
                imm    = pc + XLEN'(4);
                br_off = sx(imm_j);
                is_jal = 1'b1;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    rs1_rd_en      = 1'b1;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.alu_src   = ALU_SRC_IMM;
                    ctrl.reg_write = 1'b1;
                    imm     = pc + XLEN'(4);
                    br_off  = sx(imm_i);
                    is_jalr = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (f3 != 3'b010 && f3 != 3'b011) begin
                    rs1_rd_en      = 1'b1;
                    rs2_rd_en      = 1'b1;
                    ctrl.is_branch = 1'b1;
                    ctrl.br_funct  = f3;
                    imm    = sx(imm_b);
                    br_off = sx(imm_b);
                    is_br  = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                rs1_rd_en       = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = ALU_SRC_IMM;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                imm = sx(imm_i);
                case (f3)
                    3'b000:  ctrl.mask = MASK_B;
                    3'b001:  ctrl.mask = MASK_H;
                    3'b010:  ctrl.mask = MASK_W;
                    3'b100:  begin ctrl.mask = MASK_B; ctrl.unsigned_load = 1'b1; end
                    3'b101:  begin ctrl.mask = MASK_H; ctrl.unsigned_load = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                rs1_rd_en      = 1'b1;
                rs2_rd_en      = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = ALU_SRC_IMM;
                ctrl.mem_write = 1'b1;
                imm = sx(imm_s);
                case (f3)
                    3'b000:  ctrl.mask = MASK_B;
                    3'b001:  ctrl.mask = MASK_H;
                    3'b010:  ctrl.mask = MASK_W;
                    default: illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                rs1_rd_en      = 1'b1;
                ctrl.alu_src   = ALU_SRC_IMM;
                ctrl.reg_write = 1'b1;
                imm = sx(imm_i);
                case (f3)
                    3'b000: ctrl.alu_op = ALU_ADD;
                    3'b010: ctrl.alu_op = ALU_SLT;
                    3'b011: ctrl.alu_op = ALU_SLTU;
                    3'b100: ctrl.alu_op = ALU_XOR;
                    3'b110: ctrl.alu_op = ALU_OR;
                    3'b111: ctrl.alu_op = ALU_AND;
                    3'b001: begin
                        imm = XLEN'(inst[24:20]);
                        if (f7 == F7_ZERO) ctrl.alu_op = ALU_SLL;
                        else               illegal = 1'b1;
                    end
                    default: begin
                        imm = XLEN'(inst[24:20]);
                        if (f7 == F7_ZERO)     ctrl.alu_op = ALU_SRL;
                        else if (f7 == F7_ALT) ctrl.alu_op = ALU_SRA;
                        else                   illegal = 1'b1;
                    end
                endcase
            end
            OP_REG: begin
                rs1_rd_en      = 1'b1;
                rs2_rd_en      = 1'b1;
                ctrl.reg_write = 1'b1;
                if (f7 == F7_ZERO) begin
                    case (f3)
                        3'b000:  ctrl.alu_op = ALU_ADD;
                        3'b001:  ctrl.alu_op = ALU_SLL;
                        3'b010:  ctrl.alu_op = ALU_SLT;
                        3'b011:  ctrl.alu_op = ALU_SLTU;
                        3'b100:  ctrl.alu_op = ALU_XOR;
                        3'b101:  ctrl.alu_op = ALU_SRL;
                        3'b110:  ctrl.alu_op = ALU_OR;
                        default: ctrl.alu_op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    ctrl.alu_op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    ctrl.alu_op = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        // Illegal words must not read registers (no false hazards) nor carry an immediate
        if (illegal) begin
            rs1_rd_en = 1'b0;
            rs2_rd_en = 1'b0;
            imm       = '0;
            br_off    = '0;
            ctrl      = ID_CTRL_NOP;
            is_br     = 1'b0;
            is_jal    = 1'b0;
            is_jalr   = 1'b0;
        end
    end

    assign rs1_addr = rs1_rd_en ? inst[19:15] : 5'd0;
    assign rs2_addr = rs2_rd_en ? inst[24:20] : 5'd0;
    assign rd_addr  = ctrl.reg_write ? inst[11:7] : 5'd0;

endmodule

// File: rtl/id_pipe.sv
// Registered RV32I decode stage: decode, hazard bubbles, optional ID branch resolve, ID/EX register.
// Latency: 1 cycle from if_valid&if_ready to ex_valid; redirect is combinational in the fire cycle.
// Backpressure: ex_ready=0 with ex_valid holds every ex_* output and drops if_ready.
module id_pipe
    import id_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BRANCH_IN_ID = 1,
    parameter int FWD_W        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_inst,
    output logic             rs1_rd_en,
    output logic             rs2_rd_en,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [XLEN-1:0]  rs1_data_reg,
    input  logic [XLEN-1:0]  rs2_data_reg,
    input  logic [FWD_W-1:0] forward_op1,
    input  logic [FWD_W-1:0] forward_op2,
    input  logic [XLEN-1:0]  forward_data_mem,
    input  logic [XLEN-1:0]  forward_data_wb,
    input  logic             mem_load,
    input  logic [4:0]       mem_rd_addr,
    input  logic             flush,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_addr,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rs1_addr,
    output logic [4:0]       ex_rs2_addr,
    output logic [4:0]       ex_rd_addr,
    output logic [XLEN-1:0]  ex_imm,
    output id_ctrl_t         ex_ctrl,
    output logic             ex_illegal
);

    logic [4:0]      d_rd_addr;
    logic [XLEN-1:0] d_imm, d_br_off;
    id_ctrl_t        d_ctrl, ex_ctrl_nxt;
    logic            d_is_br, d_is_jal, d_is_jalr, d_illegal;

    id_decode #(.XLEN(XLEN)) u_decode (
        .pc        (if_pc),
        .inst      (if_inst),
        .rs1_rd_en (rs1_rd_en),
        .rs2_rd_en (rs2_rd_en),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_addr   (d_rd_addr),
        .imm       (d_imm),
        .br_off    (d_br_off),
        .ctrl      (d_ctrl),
        .is_br     (d_is_br),
        .is_jal    (d_is_jal),
        .is_jalr   (d_is_jalr),
        .illegal   (d_illegal)
    );

    id_state_e state;
    logic [1:0] bub_cnt;
    logic [1:0] hz_n;
    logic       hazard, ex_free, fire;
    logic       need1, need2, m_ex, m_mem;
    logic [XLEN-1:0] op1, op2, target;
    logic       taken;

    function automatic logic [XLEN-1:0] fwd_sel(input logic [FWD_W-1:0] sel,
                                                input logic [4:0] addr,
                                                input logic [XLEN-1:0] reg_val,
                                                input logic [XLEN-1:0] mem_val,
                                                input logic [XLEN-1:0] wb_val);
        logic [XLEN-1:0] r;
        if (addr == 5'd0)                         r = '0;
        else if (sel == FWD_W'(FORWARD_MEM))      r = mem_val;
        else if (sel == FWD_W'(FORWARD_WB))       r = wb_val;
        else                                      r = reg_val;
        return r;
    endfunction

    assign ex_free = !ex_valid || ex_ready;
    assign need1   = rs1_rd_en && (rs1_addr != 5'd0);
    assign need2   = rs2_rd_en && (rs2_addr != 5'd0);
    assign m_ex    = (need1 && rs1_addr == ex_rd_addr) || (need2 && rs2_addr == ex_rd_addr);
    assign m_mem   = mem_load &&
                     ((need1 && rs1_addr == mem_rd_addr) || (need2 && rs2_addr == mem_rd_addr));

    // Bubble count needed before the instruction in ID may issue (max over all rules)
    always_comb begin
        hz_n = 2'd0;
        if (if_valid) begin
            if (ex_valid && ex_ctrl.mem_read && m_ex)
                hz_n = 2'd1;
            if (BRANCH_IN_ID != 0 && (d_is_br || d_is_jalr)) begin
                if (ex_valid && ex_ctrl.reg_write && !ex_ctrl.mem_read && m_ex)
                    hz_n = 2'd1;
                if (m_mem)
                    hz_n = 2'd1;
                if (ex_valid && ex_ctrl.mem_read && m_ex)
                    hz_n = 2'd2;
            end
        end
    end

    assign hazard   = (hz_n != 2'd0);
    assign if_ready = rst && !flush && (state == RUN) && !hazard && ex_free;
    assign fire     = if_valid && if_ready;

    // ID branch unit: forwarded operands, condition and target
    always_comb begin
        op1   = fwd_sel(forward_op1, rs1_addr, rs1_data_reg, forward_data_mem, forward_data_wb);
        op2   = fwd_sel(forward_op2, rs2_addr, rs2_data_reg, forward_data_mem, forward_data_wb);
        taken = d_is_jal || d_is_jalr ||
                (d_is_br && br_cond(if_inst[14:12], op1 == op2,
                                    $signed(op1) < $signed(op2), op1 < op2));
        if (d_is_jalr) target = (op1 + d_br_off) & ~XLEN'(1);
        else           target = if_pc + d_br_off;
    end

    assign redirect_valid = (BRANCH_IN_ID != 0) && fire && taken;
    assign redirect_addr  = target;

    // With ID resolution the branch is finished here, so EX must not see it as a branch
    always_comb begin
        ex_ctrl_nxt = d_ctrl;
        if (BRANCH_IN_ID != 0) ex_ctrl_nxt.is_branch = 1'b0;
    end

    // ID/EX pipeline register: load on fire, bubble when EX drains, hold under backpressure
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_addr <= 5'd0;
            ex_rs2_addr <= 5'd0;
            ex_rd_addr  <= 5'd0;
            ex_imm      <= '0;
            ex_ctrl     <= ID_CTRL_NOP;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (fire) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_rs1_addr <= rs1_addr;
            ex_rs2_addr <= rs2_addr;
            ex_rd_addr  <= d_rd_addr;
            ex_imm      <= d_imm;
            ex_ctrl     <= ex_ctrl_nxt;
            ex_illegal  <= d_illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Bubble FSM: first bubble is taken from RUN, any further ones are counted down in STALL
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state   <= RUN;
            bub_cnt <= 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard && ex_free && hz_n > 2'd1) begin
                        state   <= STALL;
                        bub_cnt <= hz_n - 2'd1;
                    end
                end
                default: begin
                    if (ex_free) begin
                        if (bub_cnt <= 2'd1) begin
                            state   <= RUN;
                            bub_cnt <= 2'd0;
                        end else begin
                            bub_cnt <= bub_cnt - 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
